seq_detect_param: RTL and testbench

Parametrised serial pattern detector with a saturating match counter. It samples a one-bit stream and raises a one-cycle pulse each time the last PAT_W bits equal a programmable pattern. Overlapping or non-overlapping detection is selected at build time, and the pattern can be reloaded at run time. It supersedes the fixed "010" detector in the serial-input front end and keeps the same default behaviour: pattern 010 and a 10-bit count.

---
 rtl/seq_detect_param.sv | 79 +++++++
 tb/tb_seq_detect_param.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a run-time reloadable pattern and a saturating match counter.
// Overlapping vs. non-overlapping detection is fixed by the OVERLAP parameter.
module seq_detect_param #(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b010,
  parameter int               CNT_W   = 10,
  parameter bit               OVERLAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             pat_we,
  input  logic [PAT_W-1:0] pat_wdata,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam int               FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              y_q, y_d;
  logic [PAT_W-1:0]  word;
  logic              match;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    cnt_d  = cnt_q;
    y_d    = 1'b0;
    match  = 1'b0;
    word   = {hist_q, x};
    if (pat_we) begin
      // Reload wins over en: the bit on this edge is dropped and history restarts.
      pat_d  = pat_wdata;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      match  = (fill_q == FILL_MAX) && (word == pat_q);
      hist_d = word[PAT_W-2:0];
      if (fill_q != FILL_MAX) fill_d = fill_q + FILL_W'(1);
      if (match) begin
        y_d = 1'b1;
        if (!OVERLAP) fill_d = '0;
      end
    end
    if (cnt_clr)                        cnt_d = '0;
    else if (match && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PATTERN;
      cnt_q  <= '0;
      y_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      cnt_q  <= cnt_d;
      y_q    <= y_d;
    end
  end

  assign y     = y_q;
  assign count = cnt_q;
  assign sat   = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three instances (overlap, non-overlap, 2-bit counter) share one
// stimulus stream; a table, hand sequences and random traffic are checked against a bit-window model.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, x = 1'b0, pat_we = 1'b0, cnt_clr = 1'b0;
  logic [2:0] pat_wdata = 3'b000;
  logic y_a, y_b, y_c, sat_a, sat_b, sat_c;
  logic [9:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(3), .PATTERN(3'b010), .CNT_W(10), .OVERLAP(1'b1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .x(x), .pat_we(pat_we), .pat_wdata(pat_wdata),
    .cnt_clr(cnt_clr), .y(y_a), .count(cnt_a), .sat(sat_a));
  seq_detect_param #(.PAT_W(3), .PATTERN(3'b010), .CNT_W(10), .OVERLAP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .x(x), .pat_we(pat_we), .pat_wdata(pat_wdata),
    .cnt_clr(cnt_clr), .y(y_b), .count(cnt_b), .sat(sat_b));
  seq_detect_param #(.PAT_W(3), .PATTERN(3'b010), .CNT_W(2), .OVERLAP(1'b0)) dut_c (
    .clk(clk), .rst(rst), .en(en), .x(x), .pat_we(pat_we), .pat_wdata(pat_wdata),
    .cnt_clr(cnt_clr), .y(y_c), .count(cnt_c), .sat(sat_c));

  int total = 0, bad = 0;

  // Reference model: the last up-to-3 accepted bits as an integer plus how many are valid.
  int  mwin[3], mlen[3], mpat[3], mcnt[3];
  bit  my[3];
  int  maxc[3] = '{1023, 1023, 3};
  bit  ov[3]   = '{1'b1, 1'b0, 1'b0};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mwin[i] = 0; mlen[i] = 0; mpat[i] = 2; mcnt[i] = 0; my[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit e, input bit xx, input bit we, input int wd, input bit clr);
    bit m;
    for (int i = 0; i < 3; i++) begin
      m = 1'b0;
      if (we) begin
        mpat[i] = wd; mwin[i] = 0; mlen[i] = 0;
      end else if (e) begin
        mwin[i] = ((mwin[i] * 2) + int'(xx)) % 8;
        mlen[i] = (mlen[i] < 3) ? mlen[i] + 1 : 3;
        m = (mlen[i] == 3) && (mwin[i] == mpat[i]);
        if (m && !ov[i]) mlen[i] = 0;
      end
      my[i] = m;
      if (clr)    mcnt[i] = 0;
      else if (m) mcnt[i] = (mcnt[i] < maxc[i]) ? mcnt[i] + 1 : maxc[i];
    end
  endtask

  task automatic check_model();
    chk("y_a", int'(y_a), int'(my[0]));
    chk("cnt_a", int'(cnt_a), mcnt[0]);
    chk("sat_a", int'(sat_a), int'(mcnt[0] == maxc[0]));
    chk("y_b", int'(y_b), int'(my[1]));
    chk("cnt_b", int'(cnt_b), mcnt[1]);
    chk("sat_b", int'(sat_b), int'(mcnt[1] == maxc[1]));
    chk("y_c", int'(y_c), int'(my[2]));
    chk("cnt_c", int'(cnt_c), mcnt[2]);
    chk("sat_c", int'(sat_c), int'(mcnt[2] == maxc[2]));
  endtask

  task automatic step(input bit e, input bit xx, input bit we, input int wd, input bit clr);
    en = e; x = xx; pat_we = we; pat_wdata = wd[2:0]; cnt_clr = clr;
    @(posedge clk);
    model_step(e, xx, we, wd, clr);
    #1;
    check_model();
    en = 1'b0; pat_we = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_y", int'(y_a | y_b | y_c), 0);
    chk("rst_cnt", int'(cnt_a) + int'(cnt_b) + int'(cnt_c), 0);
    chk("rst_sat", int'(sat_a | sat_b | sat_c), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit rs; bit e; bit xx; bit we; int wd;
    bit ya; int ca; bit yb; int cb;
  } vec_t;
  vec_t tbl[22];

  initial begin
    // rs e x we wd | y_a cnt_a y_b cnt_b
    tbl[0]  = '{1,1,0,0,0, 0,0,0,0};
    tbl[1]  = '{0,1,1,0,0, 0,0,0,0};
    tbl[2]  = '{0,1,0,0,0, 1,1,1,1};
    tbl[3]  = '{0,1,1,0,0, 0,1,0,1};
    tbl[4]  = '{0,1,0,0,0, 1,2,0,1};
    tbl[5]  = '{0,1,0,0,0, 0,2,0,1};
    tbl[6]  = '{0,1,1,0,0, 0,2,0,1};
    tbl[7]  = '{0,1,0,0,0, 1,3,1,2};
    tbl[8]  = '{1,1,0,0,0, 0,0,0,0};
    tbl[9]  = '{0,0,1,0,0, 0,0,0,0};
    tbl[10] = '{0,0,1,0,0, 0,0,0,0};
    tbl[11] = '{0,0,1,0,0, 0,0,0,0};
    tbl[12] = '{0,1,1,0,0, 0,0,0,0};
    tbl[13] = '{0,1,0,0,0, 1,1,1,1};
    tbl[14] = '{0,1,0,0,0, 0,1,0,1};
    tbl[15] = '{0,1,1,0,0, 0,1,0,1};
    tbl[16] = '{0,1,1,1,7, 0,1,0,1};
    tbl[17] = '{0,1,1,0,0, 0,1,0,1};
    tbl[18] = '{0,1,1,0,0, 0,1,0,1};
    tbl[19] = '{0,1,1,0,0, 1,2,1,2};
    tbl[20] = '{0,1,1,0,0, 1,3,0,2};
    tbl[21] = '{0,0,1,0,0, 0,3,0,2};

    model_reset();
    #2;
    do_reset();

    for (int i = 0; i < 22; i++) begin
      if (tbl[i].rs) do_reset();
      step(tbl[i].e, tbl[i].xx, tbl[i].we, tbl[i].wd, 1'b0);
      chk($sformatf("tbl%0d_ya", i), int'(y_a), int'(tbl[i].ya));
      chk($sformatf("tbl%0d_ca", i), int'(cnt_a), tbl[i].ca);
      chk($sformatf("tbl%0d_yb", i), int'(y_b), int'(tbl[i].yb));
      chk($sformatf("tbl%0d_cb", i), int'(cnt_b), tbl[i].cb);
    end

    // Saturation of the 2-bit counter: five non-overlapping 010 matches.
    do_reset();
    for (int r = 0; r < 5; r++) begin
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
    end
    chk("sat_cnt_c", int'(cnt_c), 3);
    chk("sat_flag_c", int'(sat_c), 1);
    chk("sat_cnt_b", int'(cnt_b), 5);

    // Asynchronous reset mid-stream, between edges.
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_y", int'(y_a | y_b | y_c), 0);
    chk("arst_cnt_b", int'(cnt_b), 0);
    chk("arst_cnt_c", int'(cnt_c), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, 0, 0);
    chk("arst_nopulse", int'(y_a | y_b | y_c), 0);

    // Clear colliding with a match: y still pulses, count goes to 0.
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    chk("clr_y_a", int'(y_a), 1);
    chk("clr_cnt_a", int'(cnt_a), 0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(3) != 0), 1'($urandom), ($urandom_range(19) == 0),
           int'($urandom_range(7)), ($urandom_range(29) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
